// File: rtl/regwb_queue.sv
// Write-back queue owning the MIPS register-file write port: buffers results, drains one per cycle.
// Optional read-port forwarding of pending writes is built when REGWB_BYPASS_EN is defined.
module regwb_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [4:0]               InReg,
  input  logic [31:0]              InData,
  input  logic                     Stall,
  output logic [31:0]              WriteData,
  output logic [4:0]               WriteRegister,
  output logic                     RegWrite,
  input  logic [4:0]               ReadRegister1,
  input  logic [4:0]               ReadRegister2,
  input  logic [31:0]              RegData1,
  input  logic [31:0]              RegData2,
  output logic [31:0]              ReadData1,
  output logic [31:0]              ReadData2,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     data_q [DEPTH];
  logic [31:0]     data_d [DEPTH];
  logic [4:0]      reg_q  [DEPTH];
  logic [4:0]      reg_d  [DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop, empty, in_ready;

  always_comb begin
    in_ready = count_q < CntW'(DEPTH);
    empty    = count_q == '0;
    pop      = Reset_n && !empty && !Stall;
    // $0 writes are handshaken but never stored
    push     = InValid && in_ready && (InReg != 5'd0);
    data_d   = data_q;
    reg_d    = reg_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (push) begin
      data_d[tail_q] = InData;
      reg_d[tail_q]  = InReg;
      tail_d         = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge Clk) begin
    data_q <= data_d;
    reg_q  <= reg_d;
  end

  always_comb begin
    InReady       = in_ready;
    Empty         = empty;
    Count         = count_q;
    RegWrite      = pop;
    WriteData     = empty ? 32'd0 : data_q[head_q];
    WriteRegister = empty ? 5'd0 : reg_q[head_q];
  end

`ifdef REGWB_BYPASS_EN
  logic [PtrW-1:0] byp_idx;

  // Walk oldest to youngest so the youngest matching entry wins
  always_comb begin
    ReadData1 = RegData1;
    ReadData2 = RegData2;
    byp_idx   = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      byp_idx = head_q + PtrW'(i);
      if (CntW'(i) < count_q) begin
        if (reg_q[byp_idx] == ReadRegister1) ReadData1 = data_q[byp_idx];
        if (reg_q[byp_idx] == ReadRegister2) ReadData2 = data_q[byp_idx];
      end
    end
    if (ReadRegister1 == 5'd0) ReadData1 = 32'd0;
    if (ReadRegister2 == 5'd0) ReadData2 = 32'd0;
  end
`else
  logic unused_read_regs;
  assign unused_read_regs = ^{ReadRegister1, ReadRegister2};
  assign ReadData1 = RegData1;
  assign ReadData2 = RegData2;
`endif

endmodule

// File: tb/tb_regwb_queue.sv
// Self-checking bench for regwb_queue: queue-based reference model plus directed and random stimulus.
module tb_regwb_queue;

  localparam int DEPTH = 4;

  logic                    Clk = 1'b0;
  logic                    Reset_n = 1'b0;
  logic                    InValid = 1'b0;
  logic                    InReady;
  logic [4:0]              InReg = '0;
  logic [31:0]             InData = '0;
  logic                    Stall = 1'b0;
  logic [31:0]             WriteData;
  logic [4:0]              WriteRegister;
  logic                    RegWrite;
  logic [4:0]              ReadRegister1 = '0;
  logic [4:0]              ReadRegister2 = '0;
  logic [31:0]             RegData1 = '0;
  logic [31:0]             RegData2 = '0;
  logic [31:0]             ReadData1;
  logic [31:0]             ReadData2;
  logic [$clog2(DEPTH):0]  Count;
  logic                    Empty;

  regwb_queue #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
    .InReg(InReg), .InData(InData), .Stall(Stall),
    .WriteData(WriteData), .WriteRegister(WriteRegister), .RegWrite(RegWrite),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .RegData1(RegData1), .RegData2(RegData2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .Count(Count), .Empty(Empty)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  bit   started = 1'b0;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] ra, input logic [31:0] raw);
`ifdef REGWB_BYPASS_EN
    if (ra == 5'd0) return 32'd0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].r == ra) return q[i].d;
    end
`endif
    return raw;
  endfunction

  // Reference model: FIFO of pending writes, updated at each active edge
  always @(posedge Clk) begin
    bit rdy, drain;
    if (!Reset_n) begin
      q.delete();
      started = 1'b1;
    end else begin
      rdy   = q.size() < DEPTH;
      drain = q.size() > 0 && !Stall;
      if (drain) void'(q.pop_front());
      if (InValid && rdy && InReg != 5'd0) q.push_back('{r: InReg, d: InData});
    end
  end

  always @(negedge Clk) begin
    if (started) begin
      check("InReady", InReady, (q.size() < DEPTH) ? 1 : 0);
      check("Count", Count, q.size());
      check("Empty", Empty, (q.size() == 0) ? 1 : 0);
      check("RegWrite", RegWrite, (Reset_n && q.size() > 0 && !Stall) ? 1 : 0);
      check("WriteData", WriteData, (q.size() > 0) ? q[0].d : 32'd0);
      check("WriteRegister", WriteRegister, (q.size() > 0) ? {27'd0, q[0].r} : 32'd0);
      check("ReadData1", ReadData1, fwd(ReadRegister1, RegData1));
      check("ReadData2", ReadData2, fwd(ReadRegister2, RegData2));
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // reset
    Reset_n = 1'b0;
    cyc();
    Reset_n = 1'b1;
    @(negedge Clk);
    check("rst_count", Count, 0);
    check("rst_ready", InReady, 1);
    check("rst_empty", Empty, 1);
    check("rst_regwrite", RegWrite, 0);

    // single write, 1-cycle latency
    cyc();
    InValid = 1'b1; InReg = 5'd5; InData = 32'hDEADBEEF;
    cyc();
    InValid = 1'b0;
    @(negedge Clk);
    check("t1_regwrite", RegWrite, 1);
    check("t1_wreg", WriteRegister, 5);
    check("t1_wdata", WriteData, 32'hDEADBEEF);
    cyc();
    @(negedge Clk);
    check("t1_empty", Empty, 1);
    check("t1_count", Count, 0);

    // fill under stall, then drain in order
    cyc();
    Stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      InValid = 1'b1; InReg = 5'(i); InData = 32'(i * 32'h11);
      cyc();
    end
    InValid = 1'b0; Stall = 1'b0;
    @(negedge Clk);
    check("t2_count_full", Count, 4);
    check("t2_ready_full", InReady, 0);
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) @(negedge Clk);
      check("t2_regwrite", RegWrite, 1);
      check("t2_wreg", WriteRegister, i);
      check("t2_wdata", WriteData, i * 32'h11);
      if (i > 1) check("t2_ready_after_pop", InReady, 1);
      cyc();
    end
    @(negedge Clk);
    check("t2_empty", Empty, 1);

    // $0 write consumed, not stored
    cyc();
    InValid = 1'b1; InReg = 5'd0; InData = 32'hFFFFFFFF;
    cyc();
    InValid = 1'b0;
    @(negedge Clk);
    check("t3_ready", InReady, 1);
    check("t3_count", Count, 0);
    check("t3_regwrite", RegWrite, 0);

    // forwarding of youngest match
    cyc();
    Stall = 1'b1;
    InValid = 1'b1; InReg = 5'd7; InData = 32'hA;
    cyc();
    InData = 32'hB;
    cyc();
    InValid = 1'b0;
    ReadRegister1 = 5'd7; RegData1 = 32'h0;
    ReadRegister2 = 5'd0; RegData2 = 32'h1234;
    @(negedge Clk);
`ifdef REGWB_BYPASS_EN
    check("t4_fwd1", ReadData1, 32'hB);
    check("t4_zero2", ReadData2, 32'h0);
`else
    check("t4_pass1", ReadData1, 32'h0);
    check("t4_pass2", ReadData2, 32'h1234);
`endif
    cyc();
    Stall = 1'b0;
    repeat (3) cyc();

    // full queue, continuous traffic, pointers wrap
    Stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      InValid = 1'b1; InReg = 5'(8 + i); InData = $urandom;
      cyc();
    end
    Stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      InReg = 5'(12 + i); InData = $urandom;
      @(negedge Clk);
      check("t5_count", Count, (i == 0) ? 4 : 3);
      check("t5_regwrite", RegWrite, 1);
      cyc();
    end
    InValid = 1'b0;
    repeat (5) cyc();

    // reset with pending entries
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      InValid = 1'b1; InReg = 5'(20 + i); InData = $urandom;
      cyc();
    end
    InValid = 1'b0; Stall = 1'b0; Reset_n = 1'b0;
    @(negedge Clk);
    check("t6_regwrite_in_reset", RegWrite, 0);
    cyc();
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("t6_count", Count, 0);
      check("t6_regwrite", RegWrite, 0);
      cyc();
    end

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      Reset_n       = ($urandom_range(0, 199) != 0);
      InValid       = $urandom_range(0, 2) != 0;
      InReg         = 5'($urandom_range(0, 7));
      InData        = $urandom;
      Stall         = $urandom_range(0, 3) == 0;
      ReadRegister1 = 5'($urandom_range(0, 7));
      ReadRegister2 = 5'($urandom_range(0, 7));
      RegData1      = $urandom;
      RegData2      = $urandom;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regwb_queue.md
# regwb_queue

Write-back queue that owns the write port of the 32x32 MIPS register file. It accepts result writes from execution through a valid/ready handshake, buffers them in a small FIFO, and drains one write per cycle onto the file's WriteData/WriteRegister/RegWrite port. It discards writes to $0. Optionally, it forwards still-pending data onto the two read ports so that readers never see stale values.

## Interface
- DEPTH, 4, number of pending write entries; power of two, 2..16.
- Clk  input  1  clock; all state updates on the positive edge.
- Reset_n  input  1  reset; synchronous, active-low.
- InValid  input  1  producer has a write pending.
- InReady  output  1  queue can accept a write this cycle.
- InReg  input  5  destination register of the incoming write.
- InData  input  32  data of the incoming write.
- Stall  input  1  hold off draining this cycle.
- WriteData  output  32  to register file WriteData.
- WriteRegister  output  5  to register file WriteRegister.
- RegWrite  output  1  to register file RegWrite.
- ReadRegister1, ReadRegister2  input  5 each  read addresses, same as those presented to the file.
- RegData1, RegData2  input  32 each  raw register-file read data.
- ReadData1, ReadData2  output  32 each  corrected read data for consumers.
- Count  output  log2(DEPTH)+1  number of valid entries.
- Empty  output  1  Count == 0.

## Operation
- Circular FIFO with head pointer, tail pointer and count.
- Accept:
  - A write is accepted when InValid && InReady at the clock edge.
  - InReady = (Count < DEPTH); it is a function of state only, not of InValid or Stall.
- Writes with InReg == 0 are handshaken (consumed) but not enqueued; Count is unchanged.
- Drain:
  - RegWrite = !Empty && !Stall, combinational.
  - WriteData and WriteRegister show the head entry, and are 0 when Empty.
  - The head pops at the edge on which RegWrite = 1.
- Simultaneous accept and drain: both take effect; Count is unchanged.
- Accept when full: impossible, because InReady = 0. A drain that frees a slot raises InReady in the following cycle, not combinationally.
- Pointers wrap modulo DEPTH.
- Order is strict FIFO, so the file receives writes in acceptance order, including repeated writes to the same register.
- Read correction (see Configuration):
  - ReadDataN = 0 when ReadRegisterN == 0.
  - Otherwise ReadDataN is the youngest valid entry whose register matches; this includes the head entry being written this cycle.
  - Otherwise ReadDataN = RegDataN.
  - This path is combinational.

## Timing
- A write accepted at edge k can appear on RegWrite in cycle k+1 at the earliest. It is in the register file after edge k+1, so minimum write latency is 1 cycle from acceptance.
- Throughput is 1 accept and 1 drain per cycle.
- Reset: a Clk edge with Reset_n = 0 clears Count and both pointers.
  - After that edge: RegWrite = 0, WriteData = 0, WriteRegister = 0, Empty = 1, Count = 0, InReady = 1.
  - A handshake present on the reset edge is discarded.
  - Reset mid-operation discards all pending entries, and nothing further is written to the file.
- While Reset_n = 0, RegWrite is forced to 0 combinationally.
- Stall only blocks draining; accepts continue until full.

## Configuration
- REGWB_BYPASS_EN
  - Defined: read correction is as described in Operation, with youngest-match forwarding and the $0 force-to-zero.
  - Undefined: ReadDataN = RegDataN pass-through and no comparators are built. Consumers must wait for Empty before reading registers that may be pending.

## Test plan
- Reset, then drive InValid=1, InReg=5, InData=0xDEADBEEF for one cycle -> next cycle RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF; following cycle Empty=1, Count=0.
- Stall=1 and enqueue 4 writes (regs 1..4, data 0x11..0x44) -> Count=4, InReady=0. Release Stall -> RegWrite on 4 consecutive cycles in order 1,2,3,4, and InReady=1 after the first pop.
- Write to InReg=0 with data 0xFFFFFFFF -> InReady stays 1, Count stays 0, RegWrite never asserts.
- With REGWB_BYPASS_EN and Stall=1, enqueue reg 7 = 0xA then reg 7 = 0xB; set ReadRegister1=7 and RegData1=0x0 -> ReadData1=0xB. Set ReadRegister2=0 -> ReadData2=0. Without the macro -> ReadData1=0x0.
- Full queue with Stall=0 and InValid=1 continuously -> accept and drain each cycle with Count constant, and the pointers wrap past DEPTH-1 with no lost or duplicated writes.
- Reset_n=0 for one edge with 3 entries pending -> RegWrite=0 in the reset cycle and afterwards, Count=0, and no pending data ever reaches the file.
